// File: rtl/store_narrow_32_16.sv
// ---------------------------------------------------------------------------
// Module   : store_narrow_32_16
// Purpose  : Narrows a 32-bit byte/half/word store into one or two 16-bit
//            byte-enabled beats for a 16-bit data-memory write port.
// Options  : STORE_NARROW_ALIGN_CHECK_EN rejects misaligned or reserved sizes.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module store_narrow_32_16 #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_data_i,
  input  logic [1:0]        req_size_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [15:0]       mem_data_o,
  output logic [1:0]        mem_be_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [1:0] c_SZ_BYTE = 2'b00;
  localparam logic [1:0] c_SZ_HALF = 2'b01;
  localparam logic [1:0] c_SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LO   = 2'b01,
    S_HI   = 2'b10,
    S_RESP = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [1:0]        size_q;
  logic              err_q;

  logic              w_accept;
  logic              w_reject;
  logic              w_is_word;
  logic [ADDR_W-1:0] w_base;

`ifdef STORE_NARROW_ALIGN_CHECK_EN
  assign w_reject = (req_size_i == 2'b11)
                  | ((req_size_i == c_SZ_HALF) & req_addr_i[0])
                  | ((req_size_i == c_SZ_WORD) & (|req_addr_i[1:0]));
`else
  assign w_reject = 1'b0;
`endif

  assign w_accept  = req_valid_i & req_ready_o;
  // Size 11 only survives to here when alignment checking is off; it acts as a word.
  assign w_is_word = size_q[1];

  always_comb begin
    w_base = addr_q;
    if (w_is_word) w_base[1:0] = 2'b00;
    else           w_base[0]   = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    mem_valid_o = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    mem_be_o    = 2'b00;
    done_o      = 1'b0;
    err_o       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready_o = !rst;
        if (req_valid_i && !rst) state_d = w_reject ? S_RESP : S_LO;
      end
      S_LO: begin
        mem_valid_o = 1'b1;
        mem_addr_o  = w_base;
        if (size_q == c_SZ_BYTE) begin
          mem_data_o = {2{data_q[7:0]}};
          mem_be_o   = addr_q[0] ? 2'b10 : 2'b01;
        end else begin
          mem_data_o = data_q[15:0];
          mem_be_o   = 2'b11;
        end
        if (mem_ready_i) state_d = w_is_word ? S_HI : S_RESP;
      end
      S_HI: begin
        mem_valid_o = 1'b1;
        mem_addr_o  = w_base + ADDR_W'(2);
        mem_data_o  = data_q[31:16];
        mem_be_o    = 2'b11;
        if (mem_ready_i) state_d = S_RESP;
      end
      S_RESP: begin
        done_o  = 1'b1;
        err_o   = err_q;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= 2'b00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (w_accept) begin
        addr_q <= req_addr_i;
        data_q <= req_data_i;
        size_q <= req_size_i;
        err_q  <= w_reject;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_store_narrow_32_16.sv
// Self-checking bench for store_narrow_32_16: directed scenarios plus random
// stores checked against a lane-arithmetic reference model.
`default_nettype none

module tb_store_narrow_32_16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_size = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [15:0] mem_data;
  logic [1:0]  mem_be;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  store_narrow_32_16 #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_data_i(req_data), .req_size_i(req_size),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready),
    .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_be_o(mem_be),
    .done_o(done), .err_o(err)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [15:0] d;
    logic [1:0]  be;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    obs_done_k, obs_first_valid_k, obs_done_cnt;
  bit    obs_err, obs_unstable, obs_rdy_bad, obs_timeout, obs_rdy_after, obs_err_stray;

  // Reference model: expected beats from plain address/lane arithmetic.
  function automatic bit model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    beat_t b;
    longint unsigned base;
    exp_q.delete();
`ifdef STORE_NARROW_ALIGN_CHECK_EN
    if (s == 2'd3 || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0)) return 1'b1;
`endif
    if (s == 2'd0) begin
      b.a  = a - a % 2;
      b.d  = 16'((d % 256) * 257);
      b.be = (a % 2 == 1) ? 2'b10 : 2'b01;
      exp_q.push_back(b);
    end else if (s == 2'd1) begin
      b.a = a - a % 2; b.d = 16'(d % 65536); b.be = 2'b11;
      exp_q.push_back(b);
    end else begin
      base = longint'(a) - a % 4;
      b.a = 32'(base); b.d = 16'(d % 65536); b.be = 2'b11;
      exp_q.push_back(b);
      b.a = 32'((base + 2) % 64'h1_0000_0000); b.d = 16'(d / 65536);
      exp_q.push_back(b);
    end
    return 1'b0;
  endfunction

  // Drives one store and records what the memory side and response showed.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                          input int stall, input bit rnd_stall);
    int k, waited, need;
    bit held_pending;
    beat_t held, cur;
    obs_q.delete();
    obs_done_k = -1; obs_first_valid_k = -1; obs_done_cnt = 0; obs_err = 0;
    obs_unstable = 0; obs_rdy_bad = 0; obs_timeout = 0; obs_rdy_after = 0; obs_err_stray = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_data = d; req_size = s; mem_ready = 1'b0;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    if (!req_ready) begin obs_timeout = 1; req_valid = 1'b0; return; end
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_data = $urandom; req_size = 2'($urandom);
    waited = 0; need = rnd_stall ? int'($urandom_range(0, 3)) : stall; held_pending = 0;
    for (k = 1; k <= 60; k++) begin
      @(negedge clk);
      cur.a = mem_addr; cur.d = mem_data; cur.be = mem_be;
      if (req_ready) obs_rdy_bad = 1;
      if (err && !done) obs_err_stray = 1;
      if (mem_valid) begin
        if (obs_first_valid_k < 0) obs_first_valid_k = k;
        if (held_pending && cur !== held) obs_unstable = 1;
        if (waited < need) begin
          mem_ready = 1'b0; waited++; held = cur; held_pending = 1;
        end else begin
          mem_ready = 1'b1; obs_q.push_back(cur); waited = 0; held_pending = 0;
          need = rnd_stall ? int'($urandom_range(0, 3)) : stall;
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        held_pending = 0;
      end
      if (done) begin obs_done_k = k; obs_err = err; obs_done_cnt++; break; end
    end
    if (obs_done_k < 0) obs_timeout = 1;
    else begin
      @(negedge clk);
      obs_rdy_after = req_ready;
      if (done) obs_done_cnt++;
      mem_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_valid got=%b want=0", mem_valid); end
    total++; if ({mem_addr, mem_data, mem_be} !== 50'd0) begin bad++; $display("FAIL reset_mem_bus got=%h/%h/%b want=0", mem_addr, mem_data, mem_be); end
    total++; if ({done, err} !== 2'b00) begin bad++; $display("FAIL reset_done_err got=%b want=00", {done, err}); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b want=1", req_ready); end
  endtask

  task automatic test_byte();
    void'(model(32'h1003, 32'h0000_00A5, 2'd0));
    do_store(32'h1003, 32'h0000_00A5, 2'd0, 0, 0);
    total++; if (obs_q.size() != 1) begin bad++; $display("FAIL byte_beats got=%0d want=1", obs_q.size()); end
    else begin
      total++; if (obs_q[0] !== beat_t'({32'h1002, 16'hA5A5, 2'b10})) begin bad++; $display("FAIL byte_beat got=%h want=%h", obs_q[0], exp_q[0]); end
    end
    total++; if (obs_first_valid_k != 1) begin bad++; $display("FAIL byte_latency got=%0d want=1", obs_first_valid_k); end
    total++; if (obs_done_k != 2 || obs_err) begin bad++; $display("FAIL byte_done got=%0d/err%b want=2/err0", obs_done_k, obs_err); end
    total++; if (!obs_rdy_after || obs_rdy_bad) begin bad++; $display("FAIL byte_ready got=after%b busy%b want=after1 busy0", obs_rdy_after, obs_rdy_bad); end
  endtask

  task automatic test_word();
    void'(model(32'h2000, 32'hDEADBEEF, 2'd2));
    do_store(32'h2000, 32'hDEADBEEF, 2'd2, 0, 0);
    total++; if (obs_q.size() != 2) begin bad++; $display("FAIL word_beats got=%0d want=2", obs_q.size()); end
    else begin
      total++; if (obs_q[0] !== beat_t'({32'h2000, 16'hBEEF, 2'b11})) begin bad++; $display("FAIL word_beat0 got=%h want=%h", obs_q[0], exp_q[0]); end
      total++; if (obs_q[1] !== beat_t'({32'h2002, 16'hDEAD, 2'b11})) begin bad++; $display("FAIL word_beat1 got=%h want=%h", obs_q[1], exp_q[1]); end
    end
    total++; if (obs_done_k != 3 || obs_err) begin bad++; $display("FAIL word_done got=%0d/err%b want=3/err0", obs_done_k, obs_err); end
    total++; if (!obs_rdy_after || obs_rdy_bad) begin bad++; $display("FAIL word_ready got=after%b busy%b want=after1 busy0", obs_rdy_after, obs_rdy_bad); end
  endtask

  task automatic test_stall();
    void'(model(32'h3004, 32'h1234_5678, 2'd2));
    do_store(32'h3004, 32'h1234_5678, 2'd2, 3, 0);
    total++; if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
      bad++; $display("FAIL stall_beats got=%0d beats want=2 matching model", obs_q.size()); end
    total++; if (obs_unstable) begin bad++; $display("FAIL stall_hold got=changed want=stable"); end
    total++; if (obs_done_k != 9 || obs_done_cnt != 1) begin bad++; $display("FAIL stall_done got=k%0d n%0d want=k9 n1", obs_done_k, obs_done_cnt); end
  endtask

  task automatic test_half_unaligned();
    bit rej;
    rej = model(32'h0001, 32'hCAFE_F00D, 2'd1);
    do_store(32'h0001, 32'hCAFE_F00D, 2'd1, 0, 0);
    total++; if (obs_err !== rej) begin bad++; $display("FAIL half_err got=%b want=%b", obs_err, rej); end
    total++; if (obs_done_k != (rej ? 1 : 2)) begin bad++; $display("FAIL half_done got=%0d want=%0d", obs_done_k, rej ? 1 : 2); end
    total++; if (obs_q.size() != exp_q.size() || (!rej && obs_q[0] !== beat_t'({32'h0, 16'hF00D, 2'b11}))) begin
      bad++; $display("FAIL half_beats got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    total++; if (rej && obs_first_valid_k != -1) begin bad++; $display("FAIL half_no_valid got=%0d want=-1", obs_first_valid_k); end
  endtask

  task automatic test_rst_mid();
    int k;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h4000; req_data = 32'h0BAD_F00D; req_size = 2'd2; mem_ready = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (!(mem_valid && mem_addr == 32'h4002)) begin bad++; $display("FAIL rstmid_in_hi got=v%b a%h want=v1 a4002", mem_valid, mem_addr); end
    mem_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++; if (mem_valid || done) begin bad++; $display("FAIL rstmid_abandon got=v%b d%b want=v0 d0", mem_valid, done); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", req_ready); end
    @(negedge clk);
    total++; if (done || mem_valid) begin bad++; $display("FAIL rstmid_late got=v%b d%b want=v0 d0", mem_valid, done); end
    void'(model(32'h5000, 32'h77, 2'd0));
    do_store(32'h5000, 32'h77, 2'd0, 0, 0);
    total++; if (obs_q.size() != 1 || obs_q[0] !== exp_q[0] || obs_done_k != 2) begin
      bad++; $display("FAIL rstmid_next got=%0d beats k%0d want=1 beat k2", obs_q.size(), obs_done_k); end
  endtask

  task automatic test_wrap();
    bit rej;
    void'(model(32'hFFFF_FFFC, 32'hA1B2_C3D4, 2'd2));
    do_store(32'hFFFF_FFFC, 32'hA1B2_C3D4, 2'd2, 0, 0);
    total++; if (obs_q.size() != 2 || obs_q[1].a !== 32'hFFFF_FFFE || obs_q[1] !== exp_q[1]) begin
      bad++; $display("FAIL wrap_top got=%0d beats want=2 with beat1 at fffffffe", obs_q.size()); end
    rej = model(32'hFFFF_FFFE, 32'h5566_7788, 2'd2);
    do_store(32'hFFFF_FFFE, 32'h5566_7788, 2'd2, 0, 0);
    total++; if (obs_err !== rej || obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL wrap_unaligned got=err%b n%0d want=err%b n%0d", obs_err, obs_q.size(), rej, exp_q.size()); end
    if (!rej) begin
      total++; if (obs_q[0].a !== 32'hFFFF_FFFC || obs_q[1].a !== 32'hFFFF_FFFE) begin
        bad++; $display("FAIL wrap_addrs got=%h,%h want=fffffffc,fffffffe", obs_q[0].a, obs_q[1].a); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [1:0]  s;
    bit rej, ok;
    for (int i = 0; i < 40; i++) begin
      a = (i % 4 == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      d = $urandom;
      s = 2'($urandom_range(0, 3));
      rej = model(a, d, s);
      do_store(a, d, s, 0, 1);
      ok = !obs_timeout && obs_err == rej && obs_q.size() == exp_q.size() && obs_done_cnt == 1
           && !obs_unstable && !obs_rdy_bad && obs_rdy_after && !obs_err_stray;
      if (ok) for (int j = 0; j < obs_q.size(); j++) if (obs_q[j] !== exp_q[j]) ok = 0;
      total++; if (!ok) begin
        bad++; $display("FAIL random_%0d a=%h d=%h s=%0d got=err%b n%0d dn%0d want=err%b n%0d dn1", i, a, d, s,
                        obs_err, obs_q.size(), obs_done_cnt, rej, exp_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_word();
    test_stall();
    test_half_unaligned();
    test_rst_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/store_narrow_32_16.md
# store_narrow_32_16

Store-path narrowing unit: the write-side counterpart of the 16→32 immediate/load extender. Accepts a 32-bit store request (byte, half or word) from the datapath and emits it as one or two 16-bit beats with byte enables to the 16-bit data-memory write port, using valid/ready on both sides. Sits between the CPU's memory-stage store logic and the data-memory write interface.

## Interface
- ADDR_W, 32, byte-address width of request and memory ports

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  store request present
- req_ready  output  1  unit can accept a request (IDLE only)
- req_addr  input  ADDR_W  byte address
- req_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
- mem_valid  output  1  beat present on memory port
- mem_ready  input  1  memory accepts beat
- mem_addr  output  ADDR_W  halfword-aligned beat address (bit 0 always 0)
- mem_data  output  16  beat data
- mem_be  output  2  byte enables, bit0 = byte at even address
- done  output  1  one-cycle pulse: request finished
- err  output  1  qualifies done: request rejected, no beats issued

## Operation
- Little-endian lane mapping: byte at even address on mem_data[7:0]/mem_be[0], odd on [15:8]/mem_be[1].
- Accept on req_valid & req_ready; addr, data, size captured in registers; later changes to req_* ignored.
- Beat formation:
  - byte: one beat, mem_addr = {addr[ADDR_W-1:1],0}, mem_data = {2{data[7:0]}}, mem_be = addr[0] ? 10 : 01
  - half: one beat, mem_addr = addr, mem_data = data[15:0], mem_be = 11
  - word: beat 0 at addr, data[15:0], be 11; beat 1 at addr+2, data[31:16], be 11
- FSM states: IDLE, LO, HI, RESP.
  - IDLE: req_ready=1; on accept → LO, or → RESP with err flag when rejected (see Configuration).
  - LO: mem_valid=1, beat 0; on mem_ready → HI if word, else RESP.
  - HI: mem_valid=1, beat 1; on mem_ready → RESP.
  - RESP: done=1 (err=1 if rejected) for exactly one cycle → IDLE.
- mem_addr/mem_data/mem_be held constant while mem_valid & !mem_ready.
- err=0 whenever done=0.

## Timing
- Reset values: req_ready=0 during reset cycle, 1 the cycle after; mem_valid=0, mem_addr=0, mem_data=0, mem_be=00, done=0, err=0; state IDLE.
- Accept at cycle T → mem_valid=1 at T+1 (no combinational path req→mem).
- Byte/half with mem_ready held 1: beat at T+1, done at T+2, req_ready at T+3.
- Word with mem_ready held 1: beats T+1, T+2, done at T+3, req_ready at T+4.
- Rejected request: done=err=1 at T+1, no mem_valid.
- mem_ready stalls extend LO/HI indefinitely; mem_ready while mem_valid=0 ignored.
- No back-to-back accept: req_ready=0 from T+1 until return to IDLE.
- rst mid-operation: next cycle IDLE, mem_valid=0, no done; in-flight beat abandoned.
- Word address addr+2 wraps modulo 2^ADDR_W.

## Configuration
- STORE_NARROW_ALIGN_CHECK_EN defined: half with addr[0]=1, word with addr[1:0]≠00, or size 11 → rejected (RESP with err=1, no beats).
- Undefined: err tied 0; half uses addr with bit 0 cleared, word uses addr with bits [1:0] cleared; size 11 treated as word.

## Test plan
- Byte store addr 0x1003, data 0x000000A5, mem_ready=1 → one beat mem_addr 0x1002, mem_data 0xA5A5, mem_be 10; done at T+2.
- Word store addr 0x2000, data 0xDEADBEEF, mem_ready=1 → beats (0x2000, 0xBEEF, 11), (0x2002, 0xDEAD, 11); done at T+3, err=0.
- Word store with mem_ready low 3 cycles on each beat → mem_* stable during stalls, exactly two handshakes, one done pulse.
- Half store addr 0x0001: with macro → done=err=1 at T+1, mem_valid never 1; without macro → beat at 0x0000, be 11, err=0.
- rst asserted in HI state of word store → mem_valid 0 next cycle, no done, req_ready 1 the cycle after rst drops; new byte store then completes normally.
- Word at addr 0xFFFFFFFC → second beat mem_addr 0xFFFFFFFE; at 0xFFFFFFFE without macro → beats at 0xFFFFFFFC, 0xFFFFFFFE.
